// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP multiplier arbiter and its combinational core.
package fp_mul_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  localparam int INV  = 3;
  localparam int OVF  = 2;
  localparam int UNF  = 1;
  localparam int ZERO = 0;

  typedef struct packed {
    logic              sign;
    logic signed [9:0] exp_raw;
    logic [22:0]       mant;
    logic              a_zero;
    logic              b_zero;
    logic              a_inf;
    logic              b_inf;
  } core_out_t;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Request/response channels between the FP ALU issue logic and the shared multiplier.
interface fp_mul_arbiter_if;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_ready;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
  );
endinterface

// File: rtl/fp_mul_core.sv
// Combinational binary32 multiply core: sign, raw exponent, truncated mantissa and
// operand classification. Special-case priority is resolved by the caller.
module fp_mul_core
  import fp_mul_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output core_out_t   res_o
);

  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [47:0] prod;
  logic [9:0]  esum;
  logic        unused_lsbs;

  assign ea   = a_i[30:23];
  assign eb   = b_i[30:23];
  assign prod = {24'd0, 1'b1, a_i[22:0]} * {24'd0, 1'b1, b_i[22:0]};

  // 10 bits covers -127..384 without wrap
  assign esum = {2'b00, ea} + {2'b00, eb} - 10'(EXP_BIAS) + {9'd0, prod[47]};

  // truncation: bits below the kept mantissa are dropped
  assign unused_lsbs = ^prod[22:0];

  assign res_o.sign    = a_i[31] ^ b_i[31];
  assign res_o.exp_raw = $signed(esum);
  assign res_o.mant    = prod[47] ? prod[46:24] : prod[45:23];
  assign res_o.a_zero  = (ea == 8'd0);
  assign res_o.b_zero  = (eb == 8'd0);
  assign res_o.a_inf   = (ea == 8'(EXP_MAX));
  assign res_o.b_inf   = (eb == 8'(EXP_MAX));

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin two-port arbiter and IDLE/EXEC/RESP sequencer around the shared FP multiply core.
module fp_mul_arbiter
  import fp_mul_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  fp_mul_arbiter_if.slave         bus,
  output logic                    busy_o
);

  state_e      state_q;
  logic        last_grant_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        op_id_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [3:0]  rsp_flags_q;

  logic        grant_valid;
  logic        grant;
  logic        idle_ok;
  core_out_t   core;
  logic [31:0] res_data_d;
  logic [3:0]  res_flags_d;

  assign grant_valid = bus.req0_valid | bus.req1_valid;
  // on a tie the requester that did not win last time goes next
  assign grant       = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  assign idle_ok     = (state_q == IDLE) & ~rst_i;

  assign bus.req0_ready = idle_ok & grant_valid & ~grant;
  assign bus.req1_ready = idle_ok & grant_valid & grant;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = op_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign busy_o         = (state_q != IDLE) & ~rst_i;

  fp_mul_core u_core (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .res_o (core)
  );

  always_comb begin
    res_data_d  = {core.sign, core.exp_raw[7:0], core.mant};
    res_flags_d = 4'b0000;
    if ((core.a_zero & core.b_inf) | (core.a_inf & core.b_zero)) begin
      res_data_d       = QNAN;
      res_flags_d[INV] = 1'b1;
    end else if (core.a_inf | core.b_inf) begin
      res_data_d       = {core.sign, 8'hFF, 23'd0};
      res_flags_d[OVF] = 1'b1;
    end else if (core.a_zero | core.b_zero) begin
      res_data_d        = {core.sign, 31'd0};
      res_flags_d[ZERO] = 1'b1;
    end else if (core.exp_raw >= $signed(10'(EXP_MAX))) begin
      res_data_d       = {core.sign, 8'hFF, 23'd0};
      res_flags_d[OVF] = 1'b1;
    end else if (core.exp_raw <= $signed(10'd0)) begin
      res_data_d        = {core.sign, 31'd0};
      res_flags_d[UNF]  = 1'b1;
      res_flags_d[ZERO] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      op_id_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_flags_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            op_a_q       <= grant ? bus.req1_a : bus.req0_a;
            op_b_q       <= grant ? bus.req1_b : bus.req0_b;
            op_id_q      <= grant;
            last_grant_q <= grant;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= res_data_d;
          rsp_flags_q <= res_flags_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: arithmetic vectors, round-robin, backpressure and reset.
module tb_fp_mul_arbiter;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic busy_o;
  int   checks = 0;
  int   errors = 0;

  fp_mul_arbiter_if bus();

  fp_mul_arbiter dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 32'h4000_0000; bus.req0_b = 32'h4040_0000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h3FC0_0000; bus.req1_b = 32'h3FC0_0000;
    bus.rsp_ready  = 1'b1;
    rst_i = 1'b1;
    step(); step();
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b want 0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %b want 0", bus.req1_ready); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
    checks++; if (bus.rsp_flags !== 4'h0) begin errors++; $display("FAIL reset_rsp_flags got %h want 0", bus.rsp_flags); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b want 0", bus.rsp_id); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_i = 1'b0;
    step();
  endtask

  // single operation from one requester with rsp_ready high, checking exact latency
  task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_data, input logic [3:0] exp_flags, input string nm);
    logic [31:0] got_data;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; end
    else    begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== (id ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL %s_ready got %b want %b", nm, {bus.req1_ready, bus.req0_ready}, (id ? 2'b10 : 2'b01));
    end
    @(posedge clk_i); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checks++; if (busy_o !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s_exec got busy=%b rsp_valid=%b want busy=1 rsp_valid=0", nm, busy_o, bus.rsp_valid);
    end
    step();
    got_data = bus.rsp_data;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL %s_rsp_valid got %b want 1", nm, bus.rsp_valid); end
    checks++; if (got_data !== exp_data) begin errors++; $display("FAIL %s_data got %h want %h", nm, got_data, exp_data); end
    checks++; if (bus.rsp_flags !== exp_flags) begin errors++; $display("FAIL %s_flags got %b want %b", nm, bus.rsp_flags, exp_flags); end
    checks++; if (bus.rsp_id !== id) begin errors++; $display("FAIL %s_id got %b want %b", nm, bus.rsp_id, id); end
    step();
    checks++; if (bus.rsp_valid !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL %s_idle got rsp_valid=%b busy=%b want 0 0", nm, bus.rsp_valid, busy_o);
    end
  endtask

  task automatic test_arith();
    do_op(1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, "mul_2x3");
    do_op(1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, "mul_norm");
    do_op(1'b0, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000, "mul_sign");
    do_op(1'b1, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0100, "mul_ovf");
    do_op(1'b0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011, "mul_unf");
    do_op(1'b1, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, "mul_inv");
    do_op(1'b0, 32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 4'b0001, "mul_zero");
    do_op(1'b1, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0100, "mul_inf");
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_data;
    int          cnt;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h4000_0000; bus.req0_b = 32'h4040_0000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h3FC0_0000; bus.req1_b = 32'h3FC0_0000;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cnt = 0;
      while (bus.rsp_valid !== 1'b1 && cnt < 10) begin step(); cnt++; end
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_timeout op %0d got rsp_valid=%b want 1", i, bus.rsp_valid); end
      exp_data = (i % 2 == 0) ? 32'h40C0_0000 : 32'h4010_0000;
      checks++; if (bus.rsp_id !== 1'(i % 2)) begin errors++; $display("FAIL rr_id op %0d got %b want %0d", i, bus.rsp_id, i % 2); end
      checks++; if (bus.rsp_data !== exp_data) begin errors++; $display("FAIL rr_data op %0d got %h want %h", i, bus.rsp_data, exp_data); end
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_backpressure();
    bus.req0_valid = 1'b1; bus.req0_a = 32'hC000_0000; bus.req0_b = 32'h4040_0000;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h3FC0_0000; bus.req1_b = 32'h3FC0_0000;
    bus.rsp_ready  = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hC0C0_0000 || bus.rsp_id !== 1'b0 || bus.rsp_flags !== 4'b0000) begin
        errors++; $display("FAIL bp_hold cyc %0d got valid=%b data=%h id=%b flags=%b want 1 c0c00000 0 0000",
                           i, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_flags);
      end
      checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || busy_o !== 1'b1) begin
        errors++; $display("FAIL bp_ready cyc %0d got r0=%b r1=%b busy=%b want 0 0 1", i, bus.req0_ready, bus.req1_ready, busy_o);
      end
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    step();
    checks++; if (bus.rsp_valid !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL bp_release got rsp_valid=%b busy=%b want 0 0", bus.rsp_valid, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.req1_valid = 1'b1; bus.req1_a = 32'h4000_0000; bus.req1_b = 32'h4040_0000;
    bus.rsp_ready  = 1'b1;
    step();
    bus.req1_valid = 1'b0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_exec got busy=%b want 1", busy_o); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle got busy=%b rsp_valid=%b want 0 0", busy_o, bus.rsp_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_norsp cyc %0d got %b want 0", i, bus.rsp_valid); end
    end
    bus.req0_valid = 1'b1; bus.req0_a = 32'h4000_0000; bus.req0_b = 32'h4040_0000;
    bus.req1_valid = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_tie got r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = 32'h0; bus.req0_b = 32'h0;
    bus.req1_valid = 1'b0; bus.req1_a = 32'h0; bus.req1_b = 32'h0;
    bus.rsp_ready  = 1'b0;
    test_reset();
    test_round_robin();
    test_arith();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Two-port arbiter and sequencer for the shared single-precision floating-point multiplier. It accepts operand pairs from two requesters over valid/ready channels and grants them round-robin. It registers the operands, runs them through one combinational multiply core, and applies special-case handling: zero, infinity/NaN, overflow, underflow. It returns a tagged, flagged result on a single valid/ready response channel. It sits between the issue logic of the FP ALU and the multiplier datapath.

## Interface
- No parameters; the data width is fixed at IEEE-754 binary32.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operand pair.
- `req0_a`, `req0_b` in 32 each: requester 0 operands.
- `req0_ready` out 1: requester 0 handshake accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `rsp_valid` out 1: result available.
- `rsp_id` out 1: index of the requester that issued the result.
- `rsp_data` out 32: product.
- `rsp_flags` out 4: {inv, ovf, unf, zero}.
- `rsp_ready` in 1: consumer accepts the result.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection: if exactly one `reqN_valid` is high, grant N. If both are high, grant the requester not equal to `last_grant`.
  - `reqN_ready` = (state==IDLE) && grant==N. This is combinational, and at most one is high.
  - On valid&&ready: capture a, b and the id into operand registers, set `last_grant`=N, go to EXEC.
  - A requester may drop valid without a handshake; nothing is captured.
- EXEC (exactly one cycle): the core evaluates the registered operands. The packed result and flags are registered. Go to RESP.
- RESP:
  - `rsp_valid`=1. `rsp_id`, `rsp_data` and `rsp_flags` stay stable until `rsp_valid && rsp_ready`, then go to IDLE.
  - No new grant is made in the same cycle as the response handshake.
- Arithmetic, in priority order. Here s = a[31]^b[31], ea/eb = exponent fields, e = ea+eb-127+m47 computed in 10-bit signed.
  1. One operand has exp 0 and the other has exp 255: result 32'h7FC0_0000, flags inv.
  2. Either operand has exp 255: result {s,8'hFF,23'h0}, flag ovf.
  3. Either operand has exp 0 (denormals flush to zero): result {s,31'h0}, flag zero.
  4. e >= 255: result {s,8'hFF,23'h0}, flag ovf.
  5. e <= 0: result {s,31'h0}, flags unf|zero.
  6. Otherwise the result is {s,e[7:0],mant}.
- Mantissa handling:
  - The mantissa is m[46:24] if the 48-bit product of {1,ma}×{1,mb} has bit 47 set, else m[45:23].
  - This is truncation; there is no rounding.
- Reset:
  - State goes to IDLE and `rsp_valid`=0; an in-flight operation is discarded with no response.
  - `last_grant`=1, so requester 0 wins the first tie.
  - Operand and result registers go to 0, so `rsp_id`=0, `rsp_data`=0 and `rsp_flags`=0.
  - `req0_ready`/`req1_ready`/`busy` are all 0 while `rst` is high.

## Timing
- Request accepted at edge k → state EXEC after k → `rsp_valid` high after edge k+1.
- If `rsp_ready` is high, the response handshake completes at edge k+2.
- Minimum issue interval: 3 cycles per operation. The next request can be accepted at edge k+3.
- Response backpressure holds the FSM in RESP indefinitely; both `reqN_ready` stay 0 meanwhile.
- The ready outputs depend combinationally on `reqN_valid` (through the grant). No ready depends on `rsp_ready`.

## Structure
- Shared package `fp_mul_pkg` holds:
  - state enum {IDLE, EXEC, RESP};
  - constants EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC0_0000;
  - flag bit indices INV=3, OVF=2, UNF=1, ZERO=0.
- Sub-module `fp_mul_core` is combinational. It takes a and b and outputs:
  - sign;
  - the 10-bit signed raw exponent;
  - the 23-bit truncated mantissa;
  - the zero/inf operand classification.
- The arbiter owns the FSM, grant logic, registers and special-case priority.

## Test plan
- Normal multiply: req0 a=0x4000_0000, b=0x4040_0000 → `rsp_data`=0x40C0_0000, flags 0, `rsp_id`=0, `rsp_valid` two edges after the accept.
- Normalization and sign:
  - 0x3FC0_0000×0x3FC0_0000 → 0x4010_0000.
  - 0xC000_0000×0x4040_0000 → 0xC0C0_0000.
- Range and special cases:
  - 0x7F00_0000² → 0x7F80_0000, ovf.
  - 0x0080_0000² → 0x0000_0000, unf|zero.
  - 0x0000_0000×0x7F80_0000 → 0x7FC0_0000, inv.
- Round-robin: both requesters valid continuously after reset with distinct operands → grants 0,1,0,1. `rsp_id` alternates, and each result matches its own operands.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → response fields stay stable, both readies stay 0, `busy`=1. Then raise `rsp_ready` → handshake, then IDLE.
- Reset mid-operation: assert `rst` in EXEC → the next cycle is IDLE, `rsp_valid`=0, and no response is ever produced. A post-reset tie grants requester 0.
